// File: rtl/gsensor_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : gsensor_spi_responder
// Desc     : SPI slave model of an ADXL345-compatible G-sensor subset.
//            Mode 3 (CPOL=1, CPHA=1). The pins are oversampled by clk. The
//            block serves a small register file whose XYZ data registers are
//            loaded coherently from externally supplied samples.
// Options  : GSENSOR_RESP_INT_EN - when defined, int1 is a registered
//            DATA_READY & INT_ENABLE[7]. When undefined, int1 is tied low.
// Revision : 1.0 - initial release
// ============================================================================
module gsensor_spi_responder #(
   parameter logic [7:0] DEVID       = 8'hE5,
   parameter int         SYNC_STAGES = 2
) (
   input  logic        clk,
   input  logic        reset_n,
   input  logic        sample_valid,
   input  logic [15:0] x_in,
   input  logic [15:0] y_in,
   input  logic [15:0] z_in,
   input  logic        spi_csn,
   input  logic        spi_sclk,
   input  logic        spi_sdi,
   output logic        spi_sdo,
   output logic        spi_sdo_oe,
   output logic        measure,
   output logic        int1
);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_CMD  = 2'd1,
      ST_DATA = 2'd2
   } state_t;

   localparam logic [5:0] ADDR_DEVID       = 6'h00;
   localparam logic [5:0] ADDR_BW_RATE     = 6'h2C;
   localparam logic [5:0] ADDR_POWER_CTL   = 6'h2D;
   localparam logic [5:0] ADDR_INT_ENABLE  = 6'h2E;
   localparam logic [5:0] ADDR_INT_SOURCE  = 6'h30;
   localparam logic [5:0] ADDR_DATA_FORMAT = 6'h31;
   localparam logic [5:0] ADDR_DATAX0      = 6'h32;
   localparam logic [5:0] ADDR_DATAX1      = 6'h33;
   localparam logic [5:0] ADDR_DATAY0      = 6'h34;
   localparam logic [5:0] ADDR_DATAY1      = 6'h35;
   localparam logic [5:0] ADDR_DATAZ0      = 6'h36;
   localparam logic [5:0] ADDR_DATAZ1      = 6'h37;

   localparam logic [7:0] BW_RATE_RST      = 8'h0A;

   // ------------------------------------------------------------------------
   // Pin synchronizers and edge detection
   // ------------------------------------------------------------------------
   logic [SYNC_STAGES-1:0] csn_sync_q,  csn_sync_d;
   logic [SYNC_STAGES-1:0] sclk_sync_q, sclk_sync_d;
   logic [SYNC_STAGES-1:0] sdi_sync_q,  sdi_sync_d;
   logic                   csn_prev_q,  csn_prev_d;
   logic                   sclk_prev_q, sclk_prev_d;

   logic csn_s;
   logic sclk_s;
   logic sdi_s;
   logic csn_fall;
   logic sclk_rise;
   logic sclk_fall;

   assign csn_s     = csn_sync_q[SYNC_STAGES-1];
   assign sclk_s    = sclk_sync_q[SYNC_STAGES-1];
   assign sdi_s     = sdi_sync_q[SYNC_STAGES-1];
   assign csn_fall  = !csn_s && csn_prev_q;
   assign sclk_rise = sclk_s && !sclk_prev_q;
   assign sclk_fall = !sclk_s && sclk_prev_q;

   // Shift the raw pins through the synchronizer chains; remember last level
   always_comb begin
      csn_sync_d  = {csn_sync_q[SYNC_STAGES-2:0],  spi_csn};
      sclk_sync_d = {sclk_sync_q[SYNC_STAGES-2:0], spi_sclk};
      sdi_sync_d  = {sdi_sync_q[SYNC_STAGES-2:0],  spi_sdi};
      csn_prev_d  = csn_s;
      sclk_prev_d = sclk_s;
   end

   // Synchronizer flops; idle levels are CS high and SCLK high (mode 3)
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         csn_sync_q  <= '1;
         sclk_sync_q <= '1;
         sdi_sync_q  <= '0;
         csn_prev_q  <= 1'b1;
         sclk_prev_q <= 1'b1;
      end else begin
         csn_sync_q  <= csn_sync_d;
         sclk_sync_q <= sclk_sync_d;
         sdi_sync_q  <= sdi_sync_d;
         csn_prev_q  <= csn_prev_d;
         sclk_prev_q <= sclk_prev_d;
      end
   end

   // ------------------------------------------------------------------------
   // Register file state
   // ------------------------------------------------------------------------
   logic [7:0]  bw_rate_q,     bw_rate_d;
   logic [7:0]  power_ctl_q,   power_ctl_d;
   logic [7:0]  int_enable_q,  int_enable_d;
   logic [7:0]  data_format_q, data_format_d;
   logic [15:0] x_q, x_d;
   logic [15:0] y_q, y_d;
   logic [15:0] z_q, z_d;
   logic        data_ready_q,  data_ready_d;
   logic [15:0] pend_x_q, pend_x_d;
   logic [15:0] pend_y_q, pend_y_d;
   logic [15:0] pend_z_q, pend_z_d;
   logic        pend_valid_q,  pend_valid_d;

   // Read mux over the register map; unmapped addresses read as zero
   function automatic logic [7:0] reg_read(input logic [5:0] a);
      logic [7:0] v;
      v = 8'h00;
      case (a)
         ADDR_DEVID:       v = DEVID;
         ADDR_BW_RATE:     v = bw_rate_q;
         ADDR_POWER_CTL:   v = power_ctl_q;
         ADDR_INT_ENABLE:  v = int_enable_q;
         ADDR_INT_SOURCE:  v = {data_ready_q, 7'b0};
         ADDR_DATA_FORMAT: v = data_format_q;
         ADDR_DATAX0:      v = x_q[7:0];
         ADDR_DATAX1:      v = x_q[15:8];
         ADDR_DATAY0:      v = y_q[7:0];
         ADDR_DATAY1:      v = y_q[15:8];
         ADDR_DATAZ0:      v = z_q[7:0];
         ADDR_DATAZ1:      v = z_q[15:8];
         default:          v = 8'h00;
      endcase
      return v;
   endfunction

   // ------------------------------------------------------------------------
   // SPI protocol FSM
   // ------------------------------------------------------------------------
   state_t      state_q,   state_d;
   logic [2:0]  bit_cnt_q, bit_cnt_d;
   logic [6:0]  shift_q,   shift_d;
   logic [7:0]  tx_q,      tx_d;
   logic        sdo_q,     sdo_d;
   logic        rw_q,      rw_d;
   logic        mb_q,      mb_d;
   logic [5:0]  addr_q,    addr_d;

   logic [7:0]  rx_byte;
   logic [5:0]  next_addr;
   logic        wr_en;
   logic        dr_clear;

   // Byte as it stands once the current SDI bit is shifted in
   assign rx_byte   = {shift_q, sdi_s};
   // 6-bit add wraps 0x3F back to 0x00
   assign next_addr = mb_q ? addr_q + 6'd1 : addr_q;

   // Next-state and datapath control; CS high overrides all SCLK activity
   always_comb begin
      state_d   = state_q;
      bit_cnt_d = bit_cnt_q;
      shift_d   = shift_q;
      tx_d      = tx_q;
      sdo_d     = sdo_q;
      rw_d      = rw_q;
      mb_d      = mb_q;
      addr_d    = addr_q;
      wr_en     = 1'b0;
      dr_clear  = 1'b0;

      case (state_q)
         ST_IDLE: begin
            if (csn_fall) begin
               state_d   = ST_CMD;
               bit_cnt_d = 3'd0;
               shift_d   = 7'd0;
               sdo_d     = 1'b0;
            end
         end
         ST_CMD: begin
            if (sclk_rise) begin
               shift_d   = rx_byte[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  rw_d    = rx_byte[7];
                  mb_d    = rx_byte[6];
                  addr_d  = rx_byte[5:0];
                  tx_d    = reg_read(rx_byte[5:0]);
                  state_d = ST_DATA;
               end
            end
         end
         ST_DATA: begin
            if (rw_q) begin
               // Master samples on rising SCLK, so we present on falling
               if (sclk_fall) begin
                  sdo_d = tx_q[7];
                  tx_d  = {tx_q[6:0], 1'b0};
               end
               if (sclk_rise) begin
                  bit_cnt_d = bit_cnt_q + 3'd1;
                  if (bit_cnt_q == 3'd7) begin
                     dr_clear = (addr_q == ADDR_DATAZ1);
                     addr_d   = next_addr;
                     tx_d     = reg_read(next_addr);
                  end
               end
            end else if (sclk_rise) begin
               shift_d   = rx_byte[6:0];
               bit_cnt_d = bit_cnt_q + 3'd1;
               if (bit_cnt_q == 3'd7) begin
                  wr_en  = 1'b1;
                  addr_d = next_addr;
               end
            end
         end
         default: state_d = ST_IDLE;
      endcase

      if (csn_s) begin
         state_d  = ST_IDLE;
         sdo_d    = 1'b0;
         wr_en    = 1'b0;
         dr_clear = 1'b0;
      end
   end

   // FSM and shift datapath registers
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q   <= ST_IDLE;
         bit_cnt_q <= 3'd0;
         shift_q   <= 7'd0;
         tx_q      <= 8'd0;
         sdo_q     <= 1'b0;
         rw_q      <= 1'b0;
         mb_q      <= 1'b0;
         addr_q    <= 6'd0;
      end else begin
         state_q   <= state_d;
         bit_cnt_q <= bit_cnt_d;
         shift_q   <= shift_d;
         tx_q      <= tx_d;
         sdo_q     <= sdo_d;
         rw_q      <= rw_d;
         mb_q      <= mb_d;
         addr_q    <= addr_d;
      end
   end

   // ------------------------------------------------------------------------
   // Register writes, sample capture and DATA_READY tracking
   // ------------------------------------------------------------------------
   logic commit_direct;
   logic commit_pend;

   // Samples arriving mid-read are parked so a burst never mixes two samples
   assign commit_direct = sample_valid && (state_q != ST_DATA);
   assign commit_pend   = pend_valid_q && (state_q != ST_DATA);

   // Register-file next values
   always_comb begin
      bw_rate_d     = bw_rate_q;
      power_ctl_d   = power_ctl_q;
      int_enable_d  = int_enable_q;
      data_format_d = data_format_q;
      x_d           = x_q;
      y_d           = y_q;
      z_d           = z_q;
      data_ready_d  = data_ready_q;
      pend_x_d      = pend_x_q;
      pend_y_d      = pend_y_q;
      pend_z_d      = pend_z_q;
      pend_valid_d  = pend_valid_q;

      if (wr_en) begin
         case (addr_q)
            ADDR_BW_RATE:     bw_rate_d     = rx_byte;
            ADDR_POWER_CTL:   power_ctl_d   = rx_byte;
            ADDR_INT_ENABLE:  int_enable_d  = rx_byte;
            ADDR_DATA_FORMAT: data_format_d = rx_byte;
            default:          ;
         endcase
      end

      if (sample_valid && (state_q == ST_DATA)) begin
         pend_x_d     = x_in;
         pend_y_d     = y_in;
         pend_z_d     = z_in;
         pend_valid_d = 1'b1;
      end

      // A fresh strobe is newer than anything pending, so it wins
      if (commit_direct) begin
         x_d = x_in;
         y_d = y_in;
         z_d = z_in;
      end else if (commit_pend) begin
         x_d = pend_x_q;
         y_d = pend_y_q;
         z_d = pend_z_q;
      end
      if (state_q != ST_DATA) begin
         pend_valid_d = 1'b0;
      end

      // Set has priority over the read-out clear
      if (dr_clear) begin
         data_ready_d = 1'b0;
      end
      if (commit_direct || commit_pend) begin
         data_ready_d = 1'b1;
      end
   end

   // Register-file flops
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         bw_rate_q     <= BW_RATE_RST;
         power_ctl_q   <= 8'h00;
         int_enable_q  <= 8'h00;
         data_format_q <= 8'h00;
         x_q           <= 16'h0000;
         y_q           <= 16'h0000;
         z_q           <= 16'h0000;
         data_ready_q  <= 1'b0;
         pend_x_q      <= 16'h0000;
         pend_y_q      <= 16'h0000;
         pend_z_q      <= 16'h0000;
         pend_valid_q  <= 1'b0;
      end else begin
         bw_rate_q     <= bw_rate_d;
         power_ctl_q   <= power_ctl_d;
         int_enable_q  <= int_enable_d;
         data_format_q <= data_format_d;
         x_q           <= x_d;
         y_q           <= y_d;
         z_q           <= z_d;
         data_ready_q  <= data_ready_d;
         pend_x_q      <= pend_x_d;
         pend_y_q      <= pend_y_d;
         pend_z_q      <= pend_z_d;
         pend_valid_q  <= pend_valid_d;
      end
   end

   // ------------------------------------------------------------------------
   // Outputs
   // ------------------------------------------------------------------------
   assign spi_sdo_oe = (state_q == ST_DATA) && rw_q && !csn_s;
   assign spi_sdo    = spi_sdo_oe && sdo_q;
   assign measure    = power_ctl_q[3];

`ifdef GSENSOR_RESP_INT_EN
   logic int1_q, int1_d;

   // Data-ready interrupt, gated by INT_ENABLE[7]
   always_comb begin
      int1_d = data_ready_q && int_enable_q[7];
   end

   // Interrupt output register
   always_ff @(posedge clk) begin
      if (!reset_n) begin
         int1_q <= 1'b0;
      end else begin
         int1_q <= int1_d;
      end
   end

   assign int1 = int1_q;
`else
   assign int1 = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_gsensor_spi_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_gsensor_spi_responder
// Desc     : Scoreboard bench for gsensor_spi_responder. A mode-3 SPI master
//            drives directed transactions, and expected values are queued as
//            each transaction is issued. A monitor pairs every observed value
//            with the oldest expectation.
// Revision : 1.0 - initial release
// ============================================================================
module tb_gsensor_spi_responder;

   localparam int HALF = 80;   // SCLK half period: 8 clk cycles

`ifdef GSENSOR_RESP_INT_EN
   localparam logic [15:0] INT_EXP = 16'd1;
`else
   localparam logic [15:0] INT_EXP = 16'd0;
`endif

   logic        clk = 1'b0;
   logic        reset_n = 1'b0;
   logic        sample_valid = 1'b0;
   logic [15:0] x_in = 16'h0;
   logic [15:0] y_in = 16'h0;
   logic [15:0] z_in = 16'h0;
   logic        spi_csn = 1'b1;
   logic        spi_sclk = 1'b1;
   logic        spi_sdi = 1'b0;
   logic        spi_sdo;
   logic        spi_sdo_oe;
   logic        measure;
   logic        int1;

   always #5 clk = ~clk;

   gsensor_spi_responder #(
      .DEVID       (8'hE5),
      .SYNC_STAGES (2)
   ) dut (
      .clk          (clk),
      .reset_n      (reset_n),
      .sample_valid (sample_valid),
      .x_in         (x_in),
      .y_in         (y_in),
      .z_in         (z_in),
      .spi_csn      (spi_csn),
      .spi_sclk     (spi_sclk),
      .spi_sdi      (spi_sdi),
      .spi_sdo      (spi_sdo),
      .spi_sdo_oe   (spi_sdo_oe),
      .measure      (measure),
      .int1         (int1)
   );

   typedef struct {
      string       name;
      logic [15:0] exp;
   } exp_t;

   exp_t        exp_q[$];
   logic [15:0] obs_q[$];
   int          checks   = 0;
   int          failures = 0;

   logic [7:0]  tx_buf[16];
   logic [7:0]  rx_buf[16];
   logic        oe_any[16];
   logic        oe_all[16];

   task automatic push_exp(input string name, input logic [15:0] v);
      exp_t e;
      e.name = name;
      e.exp  = v;
      exp_q.push_back(e);
   endtask

   task automatic present(input logic [15:0] v);
      obs_q.push_back(v);
   endtask

   // Monitor: pair each observed value with the oldest expectation
   always @(posedge clk) begin
      exp_t        e;
      logic [15:0] ov;
      while (obs_q.size() > 0) begin
         ov = obs_q.pop_front();
         checks++;
         if (exp_q.size() == 0) begin
            failures++;
            $display("FAIL unexpected_obs got=%0h", ov);
         end else begin
            e = exp_q.pop_front();
            if (ov !== e.exp) begin
               failures++;
               $display("FAIL %s got=%0h exp=%0h", e.name, ov, e.exp);
            end
         end
      end
   end

   // One SCLK period: drive on falling, sample SDO just before rising
   task automatic spi_bit(input logic b, output logic r, output logic oe);
      spi_sclk = 1'b0;
      spi_sdi  = b;
      #HALF;
      r  = spi_sdo;
      oe = spi_sdo_oe;
      spi_sclk = 1'b1;
      #HALF;
   endtask

   // Full CS-framed transfer of nbits from tx_buf; optional strobe at a bit
   task automatic spi_xfer(input int nbits, input int strobe_bit);
      logic r;
      logic oe;
      int   k;
      int   idx;
      spi_csn = 1'b0;
      #HALF;
      for (int i = 0; i < nbits; i++) begin
         k   = i / 8;
         idx = 7 - (i % 8);
         if (i == strobe_bit) begin
            sample_valid = 1'b1;
            #10;
            sample_valid = 1'b0;
         end
         spi_bit(tx_buf[k][idx], r, oe);
         rx_buf[k][idx] = r;
         if (idx == 7) begin
            oe_any[k] = oe;
            oe_all[k] = oe;
         end else begin
            oe_any[k] = oe_any[k] | oe;
            oe_all[k] = oe_all[k] & oe;
         end
      end
      #HALF;
      spi_csn = 1'b1;
      #(4 * HALF);
   endtask

   task automatic write_reg(input logic [7:0] cmd, input logic [7:0] d);
      tx_buf[0] = cmd;
      tx_buf[1] = d;
      spi_xfer(16, -1);
   endtask

   task automatic read_check(input string name, input logic [7:0] cmd, input logic [7:0] exp);
      push_exp(name, {8'h00, exp});
      tx_buf[0] = cmd;
      tx_buf[1] = 8'h00;
      spi_xfer(16, -1);
      present({8'h00, rx_buf[1]});
   endtask

   task automatic strobe(input logic [15:0] x, input logic [15:0] y, input logic [15:0] z);
      x_in = x;
      y_in = y;
      z_in = z;
      sample_valid = 1'b1;
      #10;
      sample_valid = 1'b0;
      #10;
   endtask

   // Six-byte burst from DATAX0 with expected bytes queued up front
   task automatic burst_check(input string name, input logic [47:0] exp, input int strobe_bit);
      for (int b = 0; b < 6; b++) begin
         push_exp($sformatf("%s_b%0d", name, b), {8'h00, exp[47 - 8*b -: 8]});
      end
      tx_buf[0] = 8'hF2;
      for (int b = 1; b <= 6; b++) tx_buf[b] = 8'h00;
      spi_xfer(56, strobe_bit);
      for (int b = 1; b <= 6; b++) present({8'h00, rx_buf[b]});
   endtask

   initial begin
      logic r;
      logic oe;

      @(negedge clk);
      repeat (4) @(negedge clk);
      reset_n = 1'b1;
      #20;

      // Reset state
      push_exp("rst_sdo_oe",  16'd0); present({15'd0, spi_sdo_oe});
      push_exp("rst_sdo",     16'd0); present({15'd0, spi_sdo});
      push_exp("rst_measure", 16'd0); present({15'd0, measure});
      push_exp("rst_int1",    16'd0); present({15'd0, int1});

      // DEVID read, SDO enable only during the data byte
      push_exp("devid",       16'h00E5);
      push_exp("cmd_oe_any",  16'd0);
      push_exp("data_oe_all", 16'd1);
      tx_buf[0] = 8'h80;
      tx_buf[1] = 8'h00;
      spi_xfer(16, -1);
      present({8'h00, rx_buf[1]});
      present({15'd0, oe_any[0]});
      present({15'd0, oe_all[1]});
      push_exp("idle_oe", 16'd0); present({15'd0, spi_sdo_oe});

      // Write POWER_CTL and read back
      write_reg(8'h2D, 8'h08);
      push_exp("measure_set", 16'd1); present({15'd0, measure});
      read_check("power_ctl_rb", 8'hAD, 8'h08);

      // DEVID is read-only; BW_RATE reset value
      write_reg(8'h00, 8'h55);
      read_check("devid_ro", 8'h80, 8'hE5);
      read_check("bw_rate_rst", 8'hAC, 8'h0A);

      // Sample capture and multi-byte burst
      strobe(16'hFF38, 16'h0064, 16'h00C8);
      read_check("int_src_set", 8'hB0, 8'h80);
      burst_check("burst", 48'h38FF_6400_C800, -1);
      read_check("int_src_clr", 8'hB0, 8'h00);

      // Coherence: strobe during byte 3 must not tear the burst
      x_in = 16'h1234;
      y_in = 16'hABCD;
      z_in = 16'h8001;
      burst_check("coh_old", 48'h38FF_6400_C800, 24);
      read_check("int_src_pend", 8'hB0, 8'h80);
      burst_check("coh_new", 48'h3412_CDAB_0180, -1);

      // Abort after 4 data bits of a write
      tx_buf[0] = 8'h2C;
      tx_buf[1] = 8'hFF;
      spi_xfer(12, -1);
      read_check("abort_bw", 8'hAC, 8'h0A);
      read_check("abort_next", 8'h80, 8'hE5);

      // Reset in the middle of a read
      spi_csn = 1'b0;
      #HALF;
      for (int i = 0; i < 11; i++) begin
         spi_bit((i == 0) ? 1'b1 : 1'b0, r, oe);
      end
      push_exp("mid_oe", 16'd1); present({15'd0, spi_sdo_oe});
      reset_n = 1'b0;
      @(posedge clk);
      #1;
      push_exp("rst_mid_oe",      16'd0); present({15'd0, spi_sdo_oe});
      push_exp("rst_mid_measure", 16'd0); present({15'd0, measure});
      spi_csn = 1'b1;
      @(negedge clk);
      reset_n = 1'b1;
      #(4 * HALF);
      read_check("rst_power_ctl", 8'hAD, 8'h00);
      read_check("rst_data_x0",   8'hB2, 8'h00);

      // Data-ready interrupt
      write_reg(8'h2E, 8'h80);
      strobe(16'h0102, 16'h0304, 16'h0506);
      #30;
      push_exp("int1_set", INT_EXP); present({15'd0, int1});
      burst_check("int_burst", 48'h0201_0403_0605, -1);
      push_exp("int1_clr", 16'd0); present({15'd0, int1});

      repeat (4) @(posedge clk);
      #1;
      if (exp_q.size() != 0) begin
         checks++;
         failures++;
         $display("FAIL unmatched_expectations got=%0d exp=0", exp_q.size());
      end
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Bound on total run time
   initial begin
      #3_000_000;
      failures++;
      $display("FAIL watchdog got=timeout exp=finish");
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
`default_nettype wire
